// File: rtl/shift_reg_pkg.sv
// Shared mode encoding and sizing helper for the universal shift register.
// Both the top level and the frame counter import this package.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_e;

  // Counter width for a register of the given width; a 1-bit floor keeps tiny widths legal.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Counts shifts within a WIDTH-bit frame and pulses frame_done for one cycle
// after each completed frame.
module shift_frame_cnt
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          shift,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          frame_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_done;
  logic          w_done_nxt;

  // Next count and pulse; the pulse defaults low so it lasts exactly one cycle.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (!enb) begin
      w_cnt_nxt = r_cnt;
    end else if (clr) begin
      w_cnt_nxt = '0;
    end else if (shift) begin
      if (r_cnt == LAST) begin
        w_cnt_nxt  = '0;
        w_done_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + ONE;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign cnt        = r_cnt;
  assign frame_done = r_done;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift-left, shift-right and parallel load,
// with serial taps at both ends and a per-frame shift counter.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             frame_done
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  shift_mode_e      w_mode;
  logic             w_shift;
  logic             w_clr;

  assign w_mode  = shift_mode_e'(mode);
  assign w_shift = (w_mode == MODE_SHL) || (w_mode == MODE_SHR);
  assign w_clr   = (w_mode == MODE_LOAD);

  // Mode mux selecting the next register contents.
  always_comb begin
    w_data_nxt = r_data;
    case (w_mode)
      MODE_HOLD: w_data_nxt = r_data;
      MODE_SHL:  w_data_nxt = {r_data[WIDTH-2:0], sin_l};
      MODE_SHR:  w_data_nxt = {sin_r, r_data[WIDTH-1:1]};
      MODE_LOAD: w_data_nxt = pin;
      default:   w_data_nxt = r_data;
    endcase
  end

  // Data register; enb low freezes it regardless of mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= RST_VAL;
    end else if (enb) begin
      r_data <= w_data_nxt;
    end else begin
      r_data <= r_data;
    end
  end

  shift_frame_cnt #(
    .WIDTH (WIDTH)
  ) u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .shift      (w_shift),
    .clr        (w_clr),
    .cnt        (cnt),
    .frame_done (frame_done)
  );

  assign pout   = r_data;
  assign sout_l = r_data[WIDTH-1];
  assign sout_r = r_data[0];

endmodule
